// File: rtl/bcd2bin_pkg.sv
// bcd2bin shared constants and state encoding.
// Digit/field widths, iteration count, saturation value.
package bcd2bin_pkg;

  localparam int DIG_W = 4;
  localparam int DIG_N = 3;
  localparam int ITER  = 10;
  localparam int BIN_W = 10;
  localparam int BCD_W = DIG_W * DIG_N;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = 4;

  localparam logic [7:0] SAT = 8'hFF;

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

endpackage

// File: rtl/bcd2bin_adj.sv
// bcd_digit_adj: one reverse double-dabble digit fixup.
// Ports: d (4b digit in), q (d-3 when d>=8, else d).
module bcd_digit_adj
  import bcd2bin_pkg::*;
(
  input  logic [DIG_W-1:0] d,
  output logic [DIG_W-1:0] q
);

  assign q = (d >= 4'd8) ? d - 4'd3 : d;

endmodule

// File: rtl/bcd2bin.sv
// bcd2bin: 3-digit BCD to 8-bit binary, 10-cycle shift/sub-3.
// Ports: clk, rst, start, hun/ten/one in; bin, busy, done, ovf, err out.
module bcd2bin
  import bcd2bin_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIG_W-1:0] hun,
  input  logic [DIG_W-1:0] ten,
  input  logic [DIG_W-1:0] one,
  output logic [7:0]       bin,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic             err
);

  state_t state_q;
  state_t state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [SR_W-1:0]  sr_q;
  logic [SR_W-1:0]  sr_sh;
  logic [SR_W-1:0]  sr_nx;
  logic             inv_q;
  logic             go;
  logic             last;
  logic [BIN_W-1:0] r;

  logic [DIG_N-1:0][DIG_W-1:0] dig_sh;
  logic [DIG_N-1:0][DIG_W-1:0] dig_adj;

  logic [7:0] bin_q;
  logic       done_q;
  logic       ovf_q;
  logic       err_q;

  // One iteration: shift whole field right, then fix each digit.
  assign sr_sh  = sr_q >> 1;
  assign dig_sh = sr_sh[SR_W-1:BIN_W];

  for (genvar g = 0; g < DIG_N; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (dig_sh[g]),
      .q (dig_adj[g])
    );
  end

  assign sr_nx = {dig_adj, sr_sh[BIN_W-1:0]};
  assign r     = sr_nx[BIN_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = CONV;
      CONV: if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == CONV);
    go   = (state_q == IDLE) && start;
    last = busy && (cnt_q == CNT_W'(ITER - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      sr_q   <= '0;
      inv_q  <= 1'b0;
      bin_q  <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (go) begin
        sr_q  <= {hun, ten, one, {BIN_W{1'b0}}};
        cnt_q <= '0;
        inv_q <= (hun > 4'd9) | (ten > 4'd9)
               | (one > 4'd9);
      end else if (busy) begin
        sr_q  <= sr_nx;
        cnt_q <= last ? '0 : cnt_q + 1'b1;
        if (last) begin
          done_q <= 1'b1;
          if (inv_q) begin
            bin_q <= '0;
            ovf_q <= 1'b0;
            err_q <= 1'b1;
          end else if (r > 10'd255) begin
            bin_q <= SAT;
            ovf_q <= 1'b1;
            err_q <= 1'b0;
          end else begin
            bin_q <= r[7:0];
            ovf_q <= 1'b0;
            err_q <= 1'b0;
          end
        end
      end
    end
  end

  assign bin  = bin_q;
  assign done = done_q;
  assign ovf  = ovf_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd2bin.sv
// tb_bcd2bin: table vectors plus handshake corner sequences.
// Expected results queued at start, checked at done.
module tb_bcd2bin;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] hun = '0;
  logic [3:0] ten = '0;
  logic [3:0] one = '0;
  logic [7:0] bin;
  logic       busy;
  logic       done;
  logic       ovf;
  logic       err;

  bcd2bin dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .hun   (hun),
    .ten   (ten),
    .one   (one),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] o;
    logic [7:0] b;
    logic       v;
    logic       e;
  } vec_t;

  typedef struct packed {
    logic [7:0] b;
    logic       v;
    logic       e;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Counts edges from the sampling edge (i=0) to the done cycle.
  task automatic wait_done(input int pa, input int pb,
                           input bit hold, output int lat);
    exp_t x;
    lat = -1;
    for (int i = 0; i <= 40; i++) begin
      if (i > 0 && !hold) begin
        start = (i == pa) || (i == pb);
        if (start) begin
          hun = 4'd9; ten = 4'd9; one = 4'd9;
        end
      end
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
      chk("busy_during", int'(busy), 1);
    end
    if (lat < 0) begin
      chk("timeout", 0, 1);
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      chk("busy_at_done", int'(busy), 0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        x = sb.pop_front();
        chk("bin", int'(bin), int'(x.b));
        chk("ovf", int'(ovf), int'(x.v));
        chk("err", int'(err), int'(x.e));
      end
    end
  endtask

  task automatic conv(input vec_t v, input int pa, input int pb);
    int lat;
    logic [7:0] b0;
    hun = v.h; ten = v.t; one = v.o;
    start = 1'b1;
    sb.push_back({v.b, v.v, v.e});
    wait_done(pa, pb, 1'b0, lat);
    chk("latency", lat, 10);
    start = 1'b0;
    b0 = bin;
    @(posedge clk); #1;
    chk("done_single", int'(done), 0);
    chk("bin_hold", int'(bin), int'(b0));
  endtask

  vec_t tbl[10];

  initial begin
    int lat;
    int seen;
    tbl[0] = {4'd2, 4'd5, 4'd5,  8'd255, 1'b0, 1'b0};
    tbl[1] = {4'd0, 4'd0, 4'd0,  8'd0,   1'b0, 1'b0};
    tbl[2] = {4'd1, 4'd2, 4'd8,  8'h80,  1'b0, 1'b0};
    tbl[3] = {4'd0, 4'd4, 4'd2,  8'h2A,  1'b0, 1'b0};
    tbl[4] = {4'd9, 4'd9, 4'd9,  8'hFF,  1'b1, 1'b0};
    tbl[5] = {4'd2, 4'd5, 4'd6,  8'hFF,  1'b1, 1'b0};
    tbl[6] = {4'd0, 4'd10, 4'd3, 8'd0,   1'b0, 1'b1};
    tbl[7] = {4'd0, 4'd0, 4'd7,  8'd7,   1'b0, 1'b0};
    tbl[8] = {4'd15, 4'd0, 4'd0, 8'd0,   1'b0, 1'b1};
    tbl[9] = {4'd1, 4'd9, 4'd3,  8'd193, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_bin",  int'(bin),  0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ovf",  int'(ovf),  0);
    chk("rst_err",  int'(err),  0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", int'(busy), 0);

    for (int k = 0; k < 10; k++) conv(tbl[k], 0, 0);

    // Start pulses mid-conversion must be ignored.
    conv({4'd1, 4'd2, 4'd8, 8'h80, 1'b0, 1'b0}, 3, 9);

    // Start held high: back-to-back, inputs resampled.
    hun = 4'd0; ten = 4'd4; one = 4'd2;
    start = 1'b1;
    sb.push_back({8'h2A, 1'b0, 1'b0});
    sb.push_back({8'd7, 1'b0, 1'b0});
    @(posedge clk); #1;
    hun = 4'd0; ten = 4'd0; one = 4'd7;
    wait_done(0, 0, 1'b1, lat);
    chk("b2b_lat1", lat + 1, 10);
    wait_done(0, 0, 1'b1, lat);
    chk("b2b_gap", lat + 1, 11);
    start = 1'b0;
    @(posedge clk); #1;
    chk("b2b_done_single", int'(done), 0);

    // Reset mid-conversion aborts without a done.
    hun = 4'd2; ten = 4'd5; one = 4'd5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_bin",  int'(bin),  0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1;
    end
    chk("abort_no_done", seen, 0);
    conv({4'd1, 4'd0, 4'd0, 8'd100, 1'b0, 1'b0}, 0, 0);

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd2bin.md
# bcd2bin

Sequential three-digit BCD-to-binary converter (reverse double-dabble, shift-right/subtract-3). Sits downstream of the set/adjust logic of the watch: user-edited BCD digits (hundreds, tens, ones) are converted back to an 8-bit binary count for the counter core. Multi-cycle, start/done handshake, one conversion in flight at a time. Flags out-of-range results and invalid digits.

## Interface
- No parameters; widths fixed: 3 BCD digits, 10-bit internal binary, 8-bit output.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request conversion; sampled only in IDLE.
- hun  in  4  BCD hundreds digit.
- ten  in  4  BCD tens digit.
- one  in  4  BCD ones digit.
- bin  out  8  binary result; holds until next done.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse; bin/ovf/err valid from this cycle on.
- ovf  out  1  decimal value > 255.
- err  out  1  any input digit > 9.

## Operation
- States: IDLE, CONV. No separate DONE state; done is a registered pulse.
- IDLE, start=1: latch {hun,ten,one} into 12-bit BCD shift field, clear 10-bit binary field, capture err_n = (hun>9 | ten>9 | one>9), cnt=0, go CONV, busy=1.
- CONV iteration (one per cycle): shift 22-bit {bcd,binary} right 1; then for each of 3 digits independently, if digit ≥ 8 subtract 3 (4-bit, no borrow across digits). cnt increments.
- When cnt=9, the iteration is executed and the final value is written in the same edge: 10-bit result r.
  - err_n=1: bin=0, err=1, ovf=0.
  - else r>255: bin=8'hFF (saturate), ovf=1, err=0.
  - else: bin=r[7:0], ovf=0, err=0.
  - done=1 for exactly one cycle, busy=0, return to IDLE.
- Invalid digits still run all 10 iterations (uniform latency); shift-field contents are then don't-care.
- start while busy: ignored, not queued. start held high: new conversion begins in the cycle after done (back-to-back allowed, inputs resampled).
- Inputs only need to be stable at the sampling edge.

## Timing
- Reset (async, any time, including mid-conversion): state=IDLE, cnt=0, bin=0, busy=0, done=0, ovf=0, err=0, shift register=0. Aborted conversion produces no done.
- Latency: start sampled at edge k; busy high from after edge k; done high in the cycle after edge k+10; busy low in that same cycle. Throughput: one result per 11 cycles with start held high.
- done never asserted in consecutive cycles.
- bin/ovf/err change only on the done edge or on reset.

## Structure
- Shared package: BCD digit width (4), digit count (3), ITER=10, internal binary width (10), state encoding (IDLE, CONV), saturation value 8'hFF.
- One natural sub-module: bcd_digit_adj: combinational, 4-bit in/out, subtract 3 when input ≥ 8; instantiated three times in the iteration datapath.
- Top holds FSM, 4-bit iteration counter, 22-bit shift register, output registers.

## Test plan
- Reset then idle: all outputs 0; start with hun=2, ten=5, one=5 -> after 10 cycles done pulse, bin=8'd255, ovf=0, err=0, busy low in done cycle.
- Values 0,0,0 / 1,2,8 / 0,4,2 -> bin=0, 8'h80, 8'h2A respectively, each exactly 10 cycles start-to-done.
- 9,9,9 and 2,5,6 -> bin=8'hFF, ovf=1, err=0.
- 0,10,3 (invalid tens) -> bin=0, err=1, ovf=0, same latency; next valid request 0,0,7 -> bin=7, err cleared.
- start pulsed again at cycles 3 and 9 of a conversion with different digits -> ignored; result matches first request; start held high -> second done exactly 11 cycles after first.
- rst asserted at iteration 5 -> outputs clear immediately, no done; fresh start 1,0,0 afterwards -> bin=100.
